// File: rtl/sprite_blitter.sv
// Sprite blitter: scans one sprite from a colour-index ROM and emits
// clipped, optionally scaled and transparent plot strobes for the VGA writer.
module sprite_blitter #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 16,
    parameter int NUM_SPR     = 4,
    parameter int CW          = 3,
    parameter int ROM_LAT     = 1,
    parameter int SCR_W       = 320,
    parameter int SCR_H       = 240,
    parameter int TRANSPARENT = 1,
    localparam int SW  = $clog2(NUM_SPR),
    localparam int RW  = $clog2(SPR_H),
    localparam int CLW = $clog2(SPR_W),
    localparam int AW  = SW + RW + CLW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [SW-1:0] sprite_sel,
    input  logic [8:0]    base_x,
    input  logic [7:0]    base_y,
    input  logic          scale2,
    output logic [AW-1:0] rom_addr,
    input  logic [CW-1:0] rom_q,
    output logic [8:0]    outx,
    output logic [7:0]    outy,
    output logic [14:0]   outcolour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam int DXW = CLW + 1;
    localparam int DYW = RW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                         state_q;
    logic [SW-1:0]                  sel_q;
    logic [8:0]                     bx_q;
    logic [7:0]                     by_q;
    logic                           sc_q;
    logic [DXW-1:0]                 dx_q, dx_d;
    logic [DYW-1:0]                 dy_q, dy_d;
    logic [1:0]                     cnt_q;
    logic [ROM_LAT-1:0]             pv_q;
    logic [ROM_LAT-1:0][DXW-1:0]    pdx_q;
    logic [ROM_LAT-1:0][DYW-1:0]    pdy_q;

    logic                           last_x, last_y;
    logic [DXW-1:0]                 xmax;
    logic [DYW-1:0]                 ymax;
    logic [RW-1:0]                  row_d;
    logic [CLW-1:0]                 col_d;
    logic [9:0]                     sx;
    logic [8:0]                     sy;
    logic [2:0]                     idx;
    logic [14:0]                    colour;
    logic                           vis;

    // rom_addr always tracks the pixel that dx_q/dy_q will hold next cycle
    always_comb begin
        xmax   = sc_q ? DXW'(2 * SPR_W - 1) : DXW'(SPR_W - 1);
        ymax   = sc_q ? DYW'(2 * SPR_H - 1) : DYW'(SPR_H - 1);
        last_x = (dx_q == xmax);
        last_y = (dy_q == ymax);
        dx_d   = last_x ? '0 : dx_q + DXW'(1);
        dy_d   = last_x ? dy_q + DYW'(1) : dy_q;
        row_d  = sc_q ? dy_d[RW:1] : dy_d[RW-1:0];
        col_d  = sc_q ? dx_d[CLW:1] : dx_d[CLW-1:0];
    end

    always_comb begin
        sx     = {1'b0, bx_q} + 10'(pdx_q[ROM_LAT-1]);
        sy     = {1'b0, by_q} + 9'(pdy_q[ROM_LAT-1]);
        idx    = 3'(rom_q);
        colour = {{5{idx[2]}}, {5{idx[1]}}, {5{idx[0]}}};
        vis    = !(TRANSPARENT != 0 && idx == 3'd0)
                 && (sx < 10'(SCR_W)) && (sy < 9'(SCR_H));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            sc_q      <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            cnt_q     <= '0;
            pv_q      <= '0;
            pdx_q     <= '0;
            pdy_q     <= '0;
            rom_addr  <= '0;
            outx      <= '0;
            outy      <= '0;
            outcolour <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            plot     <= 1'b0;
            pv_q[0]  <= (state_q == SCAN);
            pdx_q[0] <= dx_q;
            pdy_q[0] <= dy_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pdx_q[i] <= pdx_q[i-1];
                pdy_q[i] <= pdy_q[i-1];
            end

            // clipped/transparent slots still update position and colour
            if (pv_q[ROM_LAT-1]) begin
                outx      <= sx[8:0];
                outy      <= sy[7:0];
                outcolour <= colour;
                plot      <= vis;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q    <= sprite_sel;
                        bx_q     <= base_x;
                        by_q     <= base_y;
                        sc_q     <= scale2;
                        dx_q     <= '0;
                        dy_q     <= '0;
                        rom_addr <= {sprite_sel, {(RW + CLW){1'b0}}};
                        busy     <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    dx_q     <= dx_d;
                    dy_q     <= dy_d;
                    rom_addr <= {sel_q, row_d, col_d};
                    if (last_x && last_y) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'(ROM_LAT)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (1-cycle transparent ROM, 2-cycle
// opaque ROM) checked each cycle against a slot-based pixel model.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, scale2;
    logic [1:0]  sel;
    logic [8:0]  bx;
    logic [7:0]  by;

    logic [10:0] addr_a, addr_b;
    logic [2:0]  q_a, q_b, qb1;
    logic [8:0]  xa, xb;
    logic [7:0]  ya, yb;
    logic [14:0] ca, cb;
    logic        pa, pb, ba, bb, da, db;

    logic [2:0]  img [4][16][32];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [2:0] rom_rd(input logic [10:0] a);
        return img[a[10:9]][a[8:5]][a[4:0]];
    endfunction

    always @(posedge clk) begin
        q_a <= rom_rd(addr_a);
        qb1 <= rom_rd(addr_b);
        q_b <= qb1;
    end

    sprite_blitter #(.ROM_LAT(1), .TRANSPARENT(1)) ua (
        .clock(clk), .reset(rst_n), .start(start), .sprite_sel(sel),
        .base_x(bx), .base_y(by), .scale2(scale2), .rom_addr(addr_a),
        .rom_q(q_a), .outx(xa), .outy(ya), .outcolour(ca), .plot(pa),
        .busy(ba), .done(da)
    );

    sprite_blitter #(.ROM_LAT(2), .TRANSPARENT(0)) ub (
        .clock(clk), .reset(rst_n), .start(start), .sprite_sel(sel),
        .base_x(bx), .base_y(by), .scale2(scale2), .rom_addr(addr_b),
        .rom_q(q_b), .outx(xb), .outy(yb), .outcolour(cb), .plot(pb),
        .busy(bb), .done(db)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {plot, busy, done, x, y, colour}; position/colour only when plotting
    function automatic logic [34:0] model(
        input int lat, input bit transp, input int k, input int n,
        input int dw, input logic [1:0] s, input logic [8:0] x0,
        input logic [7:0] y0, input bit sc, input int abort);
        logic [34:0] r;
        int sl, dx, dy, ax, ay, c;
        logic [2:0] idx;
        r = '0;
        if (abort >= 0 && k > abort) return r;
        r[33] = (k <= n + lat);
        r[32] = (k == n + lat + 1);
        sl = k - lat - 1;
        if (sl >= 0 && sl < n) begin
            dx  = sl % dw;
            dy  = sl / dw;
            idx = img[s][dy >> sc][dx >> sc];
            ax  = int'(x0) + dx;
            ay  = int'(y0) + dy;
            c   = (idx[2] ? 32'h7C00 : 0) + (idx[1] ? 32'h03E0 : 0)
                + (idx[0] ? 32'h001F : 0);
            if (!(transp && idx == 3'd0) && ax < 320 && ay < 240) begin
                r[34]    = 1'b1;
                r[31:23] = 9'(ax);
                r[22:15] = 8'(ay);
                r[14:0]  = 15'(c);
            end
        end
        return r;
    endfunction

    task automatic fill(input logic [2:0] v);
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 32; c++)
                    img[s][r][c] = v;
    endtask

    task automatic fill_rand();
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 32; c++)
                    img[s][r][c] = ($urandom_range(0, 2) == 0) ? 3'd0
                                   : 3'($urandom_range(1, 7));
    endtask

    // entered and left at #1 after a rising edge
    task automatic draw(input logic [1:0] s, input logic [8:0] x0,
                        input logic [7:0] y0, input bit sc,
                        input int restart, input int abort,
                        input int cnt_a, input int cnt_b);
        int n, dw, kend;
        int ma, mb, oa, ob, oda, odb;
        logic [34:0] ea, eb;
        dw = 32 << sc;
        n  = dw * (16 << sc);
        ma = 0; mb = 0; oa = 0; ob = 0; oda = 0; odb = 0;
        kend = (abort >= 0) ? abort + 4 : n + 6;
        sel = s; bx = x0; by = y0; scale2 = sc; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        sel    = ~s;
        bx     = 9'($urandom);
        by     = 8'($urandom);
        scale2 = ~sc;
        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            ea = model(1, 1'b1, k, n, dw, s, x0, y0, sc, abort);
            eb = model(2, 1'b0, k, n, dw, s, x0, y0, sc, abort);
            if (ea[34]) ma++;
            if (eb[34]) mb++;
            if (pa) oa++;
            if (pb) ob++;
            if (da) oda++;
            if (db) odb++;
            chk($sformatf("A cyc%0d", k),
                {pa, ba, da, pa ? {xa, ya, ca} : 32'h0}, ea);
            chk($sformatf("B cyc%0d", k),
                {pb, bb, db, pb ? {xb, yb, cb} : 32'h0}, eb);
            if (abort >= 0 && k == abort + 1) begin
                chk("A rst outs", {xa, ya, ca, addr_a}, 64'h0);
                chk("B rst outs", {xb, yb, cb, addr_b}, 64'h0);
            end
            @(posedge clk); #1;
            start = (k + 1 == restart);
            rst_n = !(k + 1 == abort);
        end
        start = 1'b0;
        rst_n = 1'b1;
        chk("A plots", 64'(oa), 64'(cnt_a >= 0 ? cnt_a : ma));
        chk("B plots", 64'(ob), 64'(cnt_b >= 0 ? cnt_b : mb));
        chk("A dones", 64'(oda), 64'(abort >= 0 ? 0 : 1));
        chk("B dones", 64'(odb), 64'(abort >= 0 ? 0 : 1));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; scale2 = 1'b0;
        sel = '0; bx = '0; by = '0;
        fill(3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("A reset", {pa, ba, da, xa, ya, ca, addr_a}, 64'h0);
        chk("B reset", {pb, bb, db, xb, yb, cb, addr_b}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill(3'd7);
        draw(2'd0, 9'd25, 8'd25, 1'b0, -1, -1, 512, 512);

        fill(3'd0);
        img[2][0][0] = 3'd4;
        draw(2'd2, 9'd100, 8'd50, 1'b1, -1, -1, 4, 2048);

        fill(3'd1);
        draw(2'd1, 9'd310, 8'd235, 1'b0, -1, -1, 50, 50);

        fill(3'd0);
        draw(2'd3, 9'd10, 8'd20, 1'b0, -1, -1, 0, 512);

        fill(3'd7);
        draw(2'd0, 9'd25, 8'd25, 1'b0, 100, -1, 512, 512);
        draw(2'd0, 9'd25, 8'd25, 1'b0, -1, 200, -1, -1);
        draw(2'd0, 9'd25, 8'd25, 1'b0, -1, -1, 512, 512);

        repeat (4) begin
            fill_rand();
            draw(2'($urandom), 9'($urandom), 8'($urandom),
                 1'($urandom), -1, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised sprite-to-framebuffer plotter. On a start pulse it scans one sprite from a colour-index ROM and emits one (x, y, colour, plot) tuple per cycle to the VGA plotter.
- Extends fixed-size overlay drawing (e.g. game-over sign, score digits) with:
  - multiple sprites per ROM
  - runtime position
  - 1x/2x scaling
  - transparency
  - screen clipping
  - start/busy/done handshake
- Sits between game-control FSM and the vga_adapter write port.

Parameters:
SPR_W, 32, sprite width in source pixels (power of 2)
SPR_H, 16, sprite height in source pixels (power of 2)
NUM_SPR, 4, sprites stacked in ROM (power of 2, >=2)
CW, 3, ROM colour-index width
ROM_LAT, 1, ROM read latency in cycles (1 or 2)
SCR_W, 320, screen width for clipping
SCR_H, 240, screen height for clipping
TRANSPARENT, 1, 1: index 0 not plotted; 0: index 0 plotted black

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
sprite_sel  in  log2(NUM_SPR)  sprite index, latched at start
base_x  in  9  top-left x, latched at start
base_y  in  8  top-left y, latched at start
scale2  in  1  0: 1x, 1: 2x; latched at start
rom_addr  out  log2(NUM_SPR)+log2(SPR_H)+log2(SPR_W)  {sprite, row, col}
rom_q  in  CW  ROM data, valid ROM_LAT cycles after rom_addr
outx  out  9  plot x
outy  out  8  plot y
outcolour  out  15  RGB555 plot colour
plot  out  1  write strobe for outx/outy/outcolour
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after last pixel issued

Behaviour:
- Reset (reset==0 at a clock edge):
  - All outputs 0; FSM to IDLE; address/pipeline valid bits cleared.
  - Applies mid-operation: a partially drawn sprite is abandoned, with no done pulse.
- FSM states and transitions:
  - IDLE: on start=1, latch sel/base/scale, clear dx=dy=0, go to SCAN. busy=1 next cycle.
  - SCAN: one destination pixel per cycle.
    - dx runs 0..DW-1, then dx=0 and dy++.
    - DW = SPR_W<<scale2; DH = SPR_H<<scale2.
    - After (DW-1, DH-1) is issued, go to DRAIN.
  - DRAIN: wait ROM_LAT+1 cycles for the pipeline to empty, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
  - start while not in IDLE is ignored.
  - start in the same cycle as the DONE state is ignored. Back-to-back draws therefore need start asserted in IDLE.
- ROM addressing:
  - col = dx >> scale2, row = dy >> scale2.
  - rom_addr = {sprite_sel, row, col}, registered.
  - In 2x mode each source pixel covers a 2x2 block.
- Pipeline:
  - dx, dy and a valid bit are delayed ROM_LAT stages alongside the ROM access, then registered into the outputs.
  - The first plot appears ROM_LAT+1 cycles after the first SCAN cycle.
  - Plot count per draw is exactly DW*DH, minus clipped/transparent pixels.
- Output stage:
  - outx = base_x+dx, computed 10-bit and truncated to 9.
  - outy = base_y+dy, computed 9-bit and truncated to 8.
  - Colour expansion: each index bit fills a 5-bit field, idx[2]->R, idx[1]->G, idx[0]->B. So 3'b000 -> 15'h0000, 3'b111 -> 15'h7FFF, 3'b100 -> 15'h7C00.
  - For CW>3, only the low 3 bits are used.
- plot=1 only when all of the following hold:
  - pipeline valid
  - not (TRANSPARENT && idx==0)
  - base_x+dx < SCR_W (10-bit compare)
  - base_y+dy < SCR_H (9-bit compare)
  - Clipped/transparent cycles still consume their slot and still drive outx/outy; only plot is low.
- Outside SCAN/DRAIN: plot=0; outx/outy/outcolour hold their last values.

Test Plan:
- Reset, then sel=0, base=(25,25), scale2=0, ROM all index 7 -> plot high for exactly 512 consecutive cycles. First plot at (25,25) ROM_LAT+1 cycles after SCAN entry; last at (56,40). outcolour=15'h7FFF throughout. One done pulse. busy low after.
- scale2=1, sel=2, ROM sprite 2 pixel (row0,col0)=4, rest 0, TRANSPARENT=1 -> exactly 4 plots, at (bx,by), (bx+1,by), (bx,by+1), (bx+1,by+1), colour 15'h7C00. 2048 scan slots before done.
- base=(310,235), 1x, ROM all 1 -> plots only for x in 310..319 and y in 235..239, i.e. 50 plots, colour 15'h001F. done still pulses.
- TRANSPARENT=0, ROM all 0 -> 512 plots, colour 15'h0000.
- start re-pulsed at cycle 100 of a draw -> ignored; total plots and done count unchanged.
- reset driven low at cycle 200 of a draw -> next edge: plot=0, busy=0, no done. A fresh start draws the full sprite normally.
- Repeat the first scenario with ROM_LAT=2 -> identical pixel stream shifted one cycle later.
